divi_sched: RTL and testbench
=============================

// Module: divi_sched
// PURPOSE
//  Shares one 32-bit iterative divider (operand-change-triggered, done-level output, ~33-cycle op) among NUM_REQ requesters.
//  Arbitrates requests, drives divider operands, waits out restart/settle, captures results, returns tagged responses.
//  Handles divide-by-zero locally; replays cached result when operands repeat (divider does not restart on equal operands).
//  Sits between ALU/CSR-level requesters and the divider instance.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  DATA_W      32  operand/result width; must match divider
//  SETTLE_CYC  3   cycles after operand drive during which div_done is ignored (stale done)
//  TIMEOUT_CYC 64  max cycles in WAIT before error response (optional feature only)
// PORTS
//  clk           in   1               system clock, rising edge
//  rst_n         in   1               asynchronous active-low reset
//  req_valid     in   NUM_REQ         per-requester request
//  req_ready     out  NUM_REQ         one-hot accept pulse; handshake = valid&ready
//  req_dividend  in   NUM_REQ*DATA_W  packed, requester i at [i*DATA_W +: DATA_W]
//  req_divisor   in   NUM_REQ*DATA_W  packed, same layout
//  rsp_valid     out  NUM_REQ         one-hot, 1-cycle response pulse; no backpressure
//  rsp_quotient  out  DATA_W          shared result bus, valid with rsp_valid
//  rsp_remainder out  DATA_W          shared result bus
//  rsp_err       out  1               divide-by-zero (or timeout) flag, valid with rsp_valid
//  div_dividend  out  DATA_W          to divider; registered, held stable through op
//  div_divisor   out  DATA_W          to divider; registered
//  div_done      in   1               divider done level
//  div_quotient  in   DATA_W          divider result (valid cycle after done first seen)
//  div_remainder in   DATA_W
// BEHAVIOUR
//  One clock clk; reset rst_n asynchronous, active-low. On reset: state IDLE, all outputs 0, cache invalid, RR pointer 0.
//  States: IDLE -> GRANT -> {RESP | LAUNCH} ; LAUNCH -> SETTLE -> WAIT -> CAPT -> RESP -> IDLE.
//  IDLE: if any req_valid, pick winner, go GRANT. GRANT: req_ready[w]=1 one cycle; latch operands and id.
//  GRANT decision: divisor==0 -> RESP, quotient={DATA_W{1}}, remainder=dividend, err=1, divider untouched.
//   cache hit (valid && operands == last completed) -> RESP with cached results, err=0. Else LAUNCH.
//  LAUNCH: drive div_* with latched operands (register update). SETTLE: count SETTLE_CYC, ignore div_done.
//  WAIT: stay until div_done=1 -> CAPT. CAPT: sample div_quotient/remainder into result + cache regs, cache valid.
//  RESP: rsp_valid[id]=1 one cycle with results; next IDLE. Min latency req->rsp: 3 cycles (zero/hit), ~SETTLE_CYC+37 otherwise.
//  div_* outputs keep last value in IDLE (never glitch; holding avoids spurious divider restart).
//  Requests arriving mid-op wait; req_valid deasserted before grant is dropped silently. At most one op in flight.
//  rsp_quotient/rsp_remainder/rsp_err hold last value between responses; rsp_valid is the only qualifier.
//  Reset mid-op: abort, no response issued, cache invalidated; divider left to restart on next operand change.
// CONFIGURATION
//  DIVI_SCHED_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT_CYC without div_done -> RESP with err=1,
//   quotient=0, remainder=0, cache invalidated. Not defined: WAIT waits indefinitely; no counter logic.
//  Arbitration is always round-robin: pointer advances to winner+1 after each grant.
// STRUCTURE
//  Package divi_sched_pkg: state enum (IDLE,GRANT,LAUNCH,SETTLE,WAIT,CAPT,RESP), DIV_ZERO_Q constant,
//   default DATA_W/NUM_REQ localparams.
//  Sub-module divi_rr_arbiter (NUM_REQ): req vector + pointer -> one-hot grant + encoded index, combinational.
//  Top holds FSM, operand/id latches, cache, settle/timeout counter, response regs.
// TESTING
//  100/7 from req0 -> LAUNCH, rsp_valid[0] once, q=14 r=2 err=0; div_* stable from LAUNCH to CAPT.
//  req1 and req2 assert together, RR ptr=0 -> req1 first then req2; next tie req1/req2 -> req2 served first.
//  5/0 from req3 -> rsp within 3 cycles, q=32'hFFFFFFFF r=5 err=1, div_* unchanged.
//  100/7 twice back-to-back -> second served from cache in 3 cycles, q=14 r=2, divider not relaunched.
//  rst_n low during WAIT -> all outputs 0 immediately, no rsp; then 9/4 -> q=2 r=1 (cache miss).
//  TIMEOUT_EN, div_done held 0 -> rsp err=1 q=0 r=0 after TIMEOUT_CYC in WAIT; without macro stays in WAIT.

Source files
------------

// File: rtl/divi_sched_pkg.sv
// Shared types and defaults for the divi_sched divider front end.
// The state encoding and the divide-by-zero quotient pattern live here.
package divi_sched_pkg;

    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_NUM_REQ = 4;

    // Bit replicated across DATA_W to form the divide-by-zero quotient (all ones).
    localparam logic DIV_ZERO_Q = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        LAUNCH = 3'd2,
        SETTLE = 3'd3,
        WAIT   = 3'd4,
        CAPT   = 3'd5,
        RESP   = 3'd6
    } state_t;

endpackage

// File: rtl/divi_rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after ptr wins.
// Produces a one-hot grant and the encoded winner index.
module divi_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand [NUM_REQ];
    logic             found;

    // cand[k] is the requester k positions after ptr, wrapped modulo NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum      = {1'b0, ptr} + (IDX_W+1)'(gi);
        assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                       : sum[IDX_W-1:0];
    end

    // Scan from the farthest offset down so the nearest active request is the last write.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx   = cand[k];
                found = 1'b1;
            end
        end
        if (found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/divi_sched.sv
// divi_sched: shares one operand-triggered iterative divider among NUM_REQ requesters.
// Optional WAIT timeout is compiled in when DIVI_SCHED_TIMEOUT_EN is defined.
module divi_sched
    import divi_sched_pkg::*;
#(
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SETTLE_CYC  = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
    input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_quotient,
    output logic [DATA_W-1:0]         rsp_remainder,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         div_dividend,
    output logic [DATA_W-1:0]         div_divisor,
    input  logic                      div_done,
    input  logic [DATA_W-1:0]         div_quotient,
    input  logic [DATA_W-1:0]         div_remainder
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef DIVI_SCHED_TIMEOUT_EN
    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
`else
    localparam int CNT_MAX = SETTLE_CYC;
`endif
    localparam int                 CNT_W       = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
`ifdef DIVI_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
`endif
    localparam logic [DATA_W-1:0]  ZERO_Q   = {DATA_W{DIV_ZERO_Q}};
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || SETTLE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("divi_sched: parameter out of range");
    end

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    id_reg, ptr_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [DATA_W-1:0]   op_dividend_reg, op_divisor_reg;
    logic [DATA_W-1:0]   div_dividend_reg, div_divisor_reg;
    logic                cache_valid_reg;
    logic [DATA_W-1:0]   cache_dividend_reg, cache_divisor_reg;
    logic [DATA_W-1:0]   cache_quotient_reg, cache_remainder_reg;
    logic [DATA_W-1:0]   rsp_quotient_reg, rsp_remainder_reg;
    logic                rsp_err_reg;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [DATA_W-1:0]   dividend_arr [NUM_REQ];
    logic [DATA_W-1:0]   divisor_arr  [NUM_REQ];
    logic [DATA_W-1:0]   sel_dividend, sel_divisor;
    logic                sel_zero, sel_hit;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign dividend_arr[gi] = req_dividend[gi*DATA_W +: DATA_W];
        assign divisor_arr[gi]  = req_divisor[gi*DATA_W +: DATA_W];
    end

    divi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign arb_any      = |arb_grant;
    assign sel_dividend = dividend_arr[id_reg];
    assign sel_divisor  = divisor_arr[id_reg];
    assign sel_zero     = (sel_divisor == '0);
    // The divider will not restart on unchanged operands, so a repeat must be served locally.
    assign sel_hit      = cache_valid_reg && (sel_dividend == cache_dividend_reg)
                                          && (sel_divisor  == cache_divisor_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        rsp_valid  = '0;
        case (state_reg)
            IDLE: begin
                if (arb_any) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (!req_valid[id_reg]) begin
                    state_next = IDLE;
                end else begin
                    req_ready[id_reg] = 1'b1;
                    state_next = (sel_zero || sel_hit) ? RESP : LAUNCH;
                end
            end
            LAUNCH: state_next = SETTLE;
            SETTLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (div_done) begin
                    state_next = CAPT;
                end
`ifdef DIVI_SCHED_TIMEOUT_EN
                else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = RESP;
                end
`endif
            end
            CAPT: state_next = RESP;
            RESP: begin
                rsp_valid[id_reg] = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_reg              <= '0;
            ptr_reg             <= '0;
            cnt_reg             <= '0;
            op_dividend_reg     <= '0;
            op_divisor_reg      <= '0;
            div_dividend_reg    <= '0;
            div_divisor_reg     <= '0;
            cache_valid_reg     <= 1'b0;
            cache_dividend_reg  <= '0;
            cache_divisor_reg   <= '0;
            cache_quotient_reg  <= '0;
            cache_remainder_reg <= '0;
            rsp_quotient_reg    <= '0;
            rsp_remainder_reg   <= '0;
            rsp_err_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        id_reg <= arb_idx;
                    end
                end
                GRANT: begin
                    if (req_valid[id_reg]) begin
                        ptr_reg         <= (id_reg == LAST_IDX) ? '0 : id_reg + 1'b1;
                        op_dividend_reg <= sel_dividend;
                        op_divisor_reg  <= sel_divisor;
                        if (sel_zero) begin
                            rsp_quotient_reg  <= ZERO_Q;
                            rsp_remainder_reg <= sel_dividend;
                            rsp_err_reg       <= 1'b1;
                        end else if (sel_hit) begin
                            rsp_quotient_reg  <= cache_quotient_reg;
                            rsp_remainder_reg <= cache_remainder_reg;
                            rsp_err_reg       <= 1'b0;
                        end
                    end
                end
                LAUNCH: begin
                    div_dividend_reg <= op_dividend_reg;
                    div_divisor_reg  <= op_divisor_reg;
                    cnt_reg          <= '0;
                end
                SETTLE: begin
                    cnt_reg <= (cnt_reg == SETTLE_LAST) ? '0 : cnt_reg + 1'b1;
                end
`ifdef DIVI_SCHED_TIMEOUT_EN
                WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (!div_done && cnt_reg == TIMEOUT_LAST) begin
                        rsp_quotient_reg  <= '0;
                        rsp_remainder_reg <= '0;
                        rsp_err_reg       <= 1'b1;
                        cache_valid_reg   <= 1'b0;
                    end
                end
`endif
                CAPT: begin
                    rsp_quotient_reg    <= div_quotient;
                    rsp_remainder_reg   <= div_remainder;
                    rsp_err_reg         <= 1'b0;
                    cache_valid_reg     <= 1'b1;
                    cache_dividend_reg  <= op_dividend_reg;
                    cache_divisor_reg   <= op_divisor_reg;
                    cache_quotient_reg  <= div_quotient;
                    cache_remainder_reg <= div_remainder;
                end
                default: ;
            endcase
        end
    end

    assign div_dividend  = div_dividend_reg;
    assign div_divisor   = div_divisor_reg;
    assign rsp_quotient  = rsp_quotient_reg;
    assign rsp_remainder = rsp_remainder_reg;
    assign rsp_err       = rsp_err_reg;

endmodule

// File: tb/tb_divi_sched.sv
// Directed bench for divi_sched with a behavioural operand-triggered divider model.
// Covers divide, round-robin order, divide-by-zero, cache replay, mid-op reset and WAIT timeout.
`timescale 1ns/1ps
module tb_divi_sched;
    localparam int N       = 4;
    localparam int W       = 32;
    localparam int SETTLE  = 3;
    localparam int TMO     = 64;
    localparam int DIV_LAT = 33;
    localparam int MISS_LAT = 3 + SETTLE + DIV_LAT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready, rsp_valid;
    logic [N*W-1:0]   req_dividend = '0, req_divisor = '0;
    logic [W-1:0]     rsp_quotient, rsp_remainder, div_dividend, div_divisor;
    logic [W-1:0]     div_quotient, div_remainder;
    logic             rsp_err, div_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    divi_sched #(
        .NUM_REQ(N), .DATA_W(W), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
        .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    // Divider model: restarts on any operand change, done drops one cycle late (stale done).
    logic [W-1:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;
    logic         m_done = 1'b1;
    logic         div_hang = 1'b0;
    int           m_cnt = 0;
    int           launches = 0;

    always @(posedge clk) begin
        if (div_dividend !== m_a || div_divisor !== m_b) begin
            m_a      <= div_dividend;
            m_b      <= div_divisor;
            m_cnt    <= DIV_LAT;
            m_done   <= 1'b0;
            launches <= launches + 1;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1 && !div_hang) begin
            m_cnt  <= 0;
            m_done <= 1'b1;
            m_q    <= (m_b == '0) ? '1 : m_a / m_b;
            m_r    <= (m_b == '0) ? m_a : m_a % m_b;
        end
    end

    assign div_done      = m_done;
    assign div_quotient  = m_q;
    assign div_remainder = m_r;

    logic [W-1:0] a_op [N];
    logic [W-1:0] b_op [N];
    int           n_rsp;
    int           r_idx [8];
    logic [W-1:0] r_q [8];
    logic [W-1:0] r_r [8];
    logic         r_err [8];
    int           r_lat [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the requesters in mask until exp_n responses arrive or maxcyc elapses.
    task automatic run(input logic [N-1:0] mask, input int maxcyc, input int exp_n);
        logic [N-1:0] pend = '0;
        int cyc = 0;
        n_rsp = 0;
        step();
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                req_dividend[i*W +: W] = a_op[i];
                req_divisor[i*W +: W]  = b_op[i];
            end
        end
        req_valid = mask;
        while (cyc < maxcyc && (n_rsp < exp_n || exp_n == 0)) begin
            step();
            cyc++;
            req_valid = req_valid & ~pend;
            pend = req_valid & req_ready;
            if (rsp_valid != '0 && n_rsp < 8) begin
                for (int i = 0; i < N; i++) begin
                    if (rsp_valid[i]) r_idx[n_rsp] = i;
                end
                r_q[n_rsp]   = rsp_quotient;
                r_r[n_rsp]   = rsp_remainder;
                r_err[n_rsp] = rsp_err;
                r_lat[n_rsp] = cyc;
                $display("rsp id=%0d q=%0h r=%0h err=%0b lat=%0d",
                         r_idx[n_rsp], rsp_quotient, rsp_remainder, rsp_err, cyc);
                n_rsp++;
            end
        end
        req_valid = '0;
        chk("rsp_count", n_rsp, exp_n);
    endtask

    initial begin
        int l0;
        logic [W-1:0] d_a, d_b;
        logic         seen;

        // Reset state
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_div_dividend", div_dividend, 0);
        chk("rst_div_divisor", div_divisor, 0);
        chk("rst_rsp_q", rsp_quotient, 0);
        chk("rst_rsp_r", rsp_remainder, 0);
        chk("rst_flags", {req_ready, rsp_valid, rsp_err}, 0);
        rst_n = 1'b1;
        step();

        // 100/7 from req0 through the divider
        a_op[0] = 100; b_op[0] = 7; l0 = launches;
        run(4'b0001, 200, 1);
        chk("t1_id", r_idx[0], 0);
        chk("t1_q", r_q[0], 14);
        chk("t1_r", r_r[0], 2);
        chk("t1_err", r_err[0], 0);
        chk("t1_lat", r_lat[0], MISS_LAT);
        chk("t1_launches", launches - l0, 1);
        chk("t1_div_a", div_dividend, 100);
        chk("t1_div_b", div_divisor, 7);

        // Tie req1/req2: req1 wins, then req2
        a_op[1] = 50; b_op[1] = 6; a_op[2] = 81; b_op[2] = 9;
        run(4'b0110, 300, 2);
        chk("tie1_first", r_idx[0], 1);
        chk("tie1_q0", r_q[0], 8);
        chk("tie1_r0", r_r[0], 2);
        chk("tie1_second", r_idx[1], 2);
        chk("tie1_q1", r_q[1], 9);
        chk("tie1_r1", r_r[1], 0);

        // req1 alone moves the pointer to 2, so the next req1/req2 tie serves req2 first
        a_op[1] = 1000; b_op[1] = 33;
        run(4'b0010, 200, 1);
        chk("solo1_q", r_q[0], 30);
        chk("solo1_r", r_r[0], 10);
        a_op[1] = 7; b_op[1] = 8; a_op[2] = 32'hFFFF_FFFF; b_op[2] = 16;
        run(4'b0110, 300, 2);
        chk("tie2_first", r_idx[0], 2);
        chk("tie2_q0", r_q[0], 32'h0FFF_FFFF);
        chk("tie2_r0", r_r[0], 15);
        chk("tie2_second", r_idx[1], 1);
        chk("tie2_q1", r_q[1], 0);
        chk("tie2_r1", r_r[1], 7);

        // 5/0 from req3 handled locally
        d_a = div_dividend; d_b = div_divisor; l0 = launches;
        a_op[3] = 5; b_op[3] = 0;
        run(4'b1000, 10, 1);
        chk("dz_id", r_idx[0], 3);
        chk("dz_q", r_q[0], 32'hFFFF_FFFF);
        chk("dz_r", r_r[0], 5);
        chk("dz_err", r_err[0], 1);
        chk("dz_lat_le3", r_lat[0] <= 3, 1);
        step();
        step();
        chk("dz_div_a", div_dividend, d_a);
        chk("dz_div_b", div_divisor, d_b);
        chk("dz_launches", launches - l0, 0);

        // 100/7 twice: second replayed from cache
        a_op[0] = 100; b_op[0] = 7; l0 = launches;
        run(4'b0001, 200, 1);
        chk("c1_q", r_q[0], 14);
        chk("c1_lat", r_lat[0], MISS_LAT);
        run(4'b0001, 10, 1);
        chk("c2_q", r_q[0], 14);
        chk("c2_r", r_r[0], 2);
        chk("c2_err", r_err[0], 0);
        chk("c2_lat_le3", r_lat[0] <= 3, 1);
        step();
        step();
        chk("c2_launches", launches - l0, 1);

        // Reset while in WAIT
        step();
        req_dividend[0 +: W] = 200; req_divisor[0 +: W] = 3;
        req_valid = 4'b0001;
        step();
        step();
        req_valid = '0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_div_a", div_dividend, 0);
        chk("mid_rst_div_b", div_divisor, 0);
        chk("mid_rst_rsp_q", rsp_quotient, 0);
        chk("mid_rst_rsp_r", rsp_remainder, 0);
        chk("mid_rst_flags", {req_ready, rsp_valid, rsp_err}, 0);
        step();
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | (|rsp_valid);
        end
        chk("mid_rst_no_rsp", seen, 0);
        a_op[0] = 100; b_op[0] = 7; l0 = launches;
        run(4'b0001, 200, 1);
        chk("post_rst_100_7_lat", r_lat[0], MISS_LAT);
        chk("post_rst_100_7_q", r_q[0], 14);
        a_op[0] = 9; b_op[0] = 4;
        run(4'b0001, 200, 1);
        chk("post_rst_q", r_q[0], 2);
        chk("post_rst_r", r_r[0], 1);
        chk("post_rst_lat", r_lat[0], MISS_LAT);
        chk("post_rst_launches", launches - l0, 2);

        // Divider that never finishes
        div_hang = 1'b1;
        a_op[0] = 12; b_op[0] = 5;
`ifdef DIVI_SCHED_TIMEOUT_EN
        run(4'b0001, 200, 1);
        chk("tmo_err", r_err[0], 1);
        chk("tmo_q", r_q[0], 0);
        chk("tmo_r", r_r[0], 0);
        chk("tmo_lat", r_lat[0], 3 + SETTLE + TMO);
`else
        run(4'b0001, 150, 0);
`endif
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        div_hang = 1'b0;
        a_op[2] = 60; b_op[2] = 7;
        run(4'b0100, 200, 1);
        chk("recover_q", r_q[0], 8);
        chk("recover_r", r_r[0], 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
